imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised RISC-V immediate generator for the decode stage. It accepts a 32-bit instruction on a valid/ready handshake and classifies it as R/I/S/B/U/J. It produces the XLEN-wide immediate, including B/J byte offsets with bit 0 = 0 and zero-extended shift amounts. Results are buffered in a 2-entry skid buffer so `in_ready_o` is registered. It also counts illegal opcodes and supports a flush for branch redirects.

## Interface
- `XLEN`, 32: immediate width; legal values 32 or 64.
- `TAG_W`, 8: width of the sideband tag carried alongside each instruction (e.g. ROB/PC index).
- `CNT_W`, 8: width of the saturating illegal-opcode counter.

Ports:
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `flush_i`  in  1  discard all buffered entries.
- `in_valid_i`  in  1  instruction valid.
- `in_ready_o`  out  1  block can accept.
- `instr_i`  in  32  raw instruction.
- `tag_i`  in  TAG_W  sideband, passed through unchanged.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  downstream accepts.
- `imm_o`  out  XLEN  generated immediate.
- `fmt_o`  out  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J.
- `illegal_o`  out  1  opcode not recognised.
- `tag_o`  out  TAG_W  tag of the current result.
- `illegal_cnt_o`  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
Decoding uses opcode `instr[6:0]`. sext = sign-extend to XLEN from the MSB shown.
- I-format (`0010011` OP-IMM, `0000011` LOAD, `1100111` JALR, `1110011` SYSTEM): imm = sext(`instr[31:20]`).
- OP-IMM shifts, funct3 `001`/`101`: imm = zero-extended shamt. The shamt is `instr[24:20]` when XLEN=32 and `instr[25:20]` when XLEN=64. funct7 bits never reach `imm_o`.
- S-format (`0100011`): imm = sext({`instr[31:25]`, `instr[11:7]`}).
- B-format (`1100011`): imm = sext({`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 0}).
- U-format (`0110111` LUI, `0010111` AUIPC): imm = sext({`instr[31:12]`, 12'b0}).
- J-format (`1101111`): imm = sext({`instr[31]`, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 0}).
- R-format (`0110011` OP): imm = 0.
- XLEN=64 only: `0111011` OP-32 is R-format; `0011011` OP-IMM-32 is I-format, with shamt taken from `instr[24:20]`. With XLEN=32, both opcodes are illegal.
- Any other opcode: `illegal_o`=1, imm=0, `fmt_o`=0.

Buffering: a main register drives the outputs; a skid register holds one overflow entry.
- Input is accepted when `in_valid_i` && `in_ready_o`. `in_ready_o` = !skid_valid && !`rst_i`.
- Accept with main empty, or with main being consumed this cycle and skid empty: the decoded result goes into main.
- Accept while main is full and stalled: the decoded result goes into skid.
- Main consumed while skid is full: skid moves to main, and skid becomes empty.
- Ordering is strictly FIFO. No entry is dropped or duplicated.

Counter: increments by 1 on each accepted illegal instruction and saturates at 2^CNT_W−1. It is cleared only by `rst_i`; `flush_i` does not clear it.

Flush:
- On a cycle with `flush_i`=1, main and skid valid are cleared at the edge.
- An input handshake in that same cycle is discarded, but is still counted if illegal.
- An output handshake in that same cycle completes normally.

## Timing
- Reset: `out_valid_o`=0, `imm_o`=0, `fmt_o`=0, `illegal_o`=0, `tag_o`=0, `illegal_cnt_o`=0. `in_ready_o`=0 while `rst_i`=1 and 1 in the cycle after reset deasserts.
- Latency: instruction accepted at edge N → `out_valid_o`=1 with its result from edge N+1.
- Throughput: 1 instruction/cycle while `out_ready_i`=1.
- Stall: with `out_ready_i` held at 0, at most 2 entries are accepted. `in_ready_o` falls in the cycle after the second acceptance.
- While `out_valid_o`=1 and `out_ready_i`=0, all outputs hold stable.
- Reset mid-operation: all buffered entries are lost and the outputs return to reset values at the next edge. Reset has priority over flush and over both handshakes.
- Flush: `out_valid_o`=0 and `in_ready_o`=1 from the edge after `flush_i`, unless `rst_i` is also asserted.

## Test plan
- XLEN=32, `out_ready_i`=1. Feed `0xFFF00093` (addi −1) → next cycle `imm_o`=`0xFFFFFFFF`, `fmt_o`=1. Then feed `0xFE000EE3` (beq −4) → `imm_o`=`0xFFFFFFFC`, `fmt_o`=3.
- Feed `0x123452B7` (lui) → `imm_o`=`0x12345000`, `fmt_o`=4. Feed `0x0010006F` (jal +2048) → `imm_o`=`0x00000800`, `fmt_o`=5. Feed `0x4030D093` (srai 3) → `imm_o`=`0x00000003`, `fmt_o`=1.
- Backpressure: hold `out_ready_i`=0 and offer tags 1, 2, 3 back-to-back → tags 1 and 2 accepted, `in_ready_o`=0 on the third offer. Release → tags 1, 2, 3 emerge in order on consecutive cycles, with no loss.
- Illegal: with CNT_W=2, accept `0x0000007F` five times → `illegal_o`=1 and `imm_o`=0 on each result; `illegal_cnt_o` reads 1, 2, 3, 3, 3.
- Flush with both entries full and `in_valid_i`=1 in the flush cycle → next cycle `out_valid_o`=0, `in_ready_o`=1; the flushed-cycle input never appears at the output.
- XLEN=64: feed `0xFE112C23` (sw, offset −8) → `imm_o`=`0xFFFFFFFFFFFFFFF8`. Feed `0x0050809B` (addiw 5) → `imm_o`=5, `illegal_o`=0. Repeat `0x0050809B` with XLEN=32 → `illegal_o`=1.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with a 2-entry skid buffer and an illegal-opcode counter
// Ports: clk_i/rst_i (sync active-high), flush_i drops buffered entries;
// in_valid_i/in_ready_o/instr_i/tag_i accept side; out_valid_o/out_ready_i/imm_o/fmt_o/illegal_o/tag_o result side;
// illegal_cnt_o saturating count of accepted illegal instructions.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;
  localparam bit RV64 = XLEN == 64;
  logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm, sh_imm, shw_imm, d_imm;
  logic [2:0] d_fmt;
  logic d_ill, sh, acc, pop;
  logic m_v, m_ill, k_v, k_ill;
  logic [XLEN-1:0] m_imm, k_imm;
  logic [2:0] m_fmt, k_fmt;
  logic [TAG_W-1:0] m_tag, k_tag;
  logic [CNT_W-1:0] cnt;
  // funct3 001 and 101 are the shift-immediate encodings
  assign sh = instr_i[13:12] == 2'b01;
  always_comb begin
    i_imm = {XLEN{instr_i[31]}};
    i_imm[11:0] = instr_i[31:20];
    s_imm = {XLEN{instr_i[31]}};
    s_imm[11:0] = {instr_i[31:25], instr_i[11:7]};
    b_imm = {XLEN{instr_i[31]}};
    b_imm[12:0] = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    u_imm = {XLEN{instr_i[31]}};
    u_imm[31:0] = {instr_i[31:12], 12'b0};
    j_imm = {XLEN{instr_i[31]}};
    j_imm[20:0] = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    sh_imm = '0;
    sh_imm[5:0] = {RV64 && instr_i[25], instr_i[24:20]};
    shw_imm = '0;
    shw_imm[4:0] = instr_i[24:20];
  end
  always_comb begin
    d_imm = '0;
    d_fmt = F_R;
    d_ill = 1'b0;
    case (instr_i[6:0])
      7'b0010011: begin
        d_fmt = F_I;
        d_imm = sh ? sh_imm : i_imm;
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        d_fmt = F_I;
        d_imm = i_imm;
      end
      7'b0100011: begin
        d_fmt = F_S;
        d_imm = s_imm;
      end
      7'b1100011: begin
        d_fmt = F_B;
        d_imm = b_imm;
      end
      7'b0110111, 7'b0010111: begin
        d_fmt = F_U;
        d_imm = u_imm;
      end
      7'b1101111: begin
        d_fmt = F_J;
        d_imm = j_imm;
      end
      7'b0110011: d_fmt = F_R;
      7'b0111011: d_ill = !RV64;
      7'b0011011: begin
        d_ill = !RV64;
        d_fmt = RV64 ? F_I : F_R;
        d_imm = !RV64 ? '0 : sh ? shw_imm : i_imm;
      end
      default: d_ill = 1'b1;
    endcase
  end
  assign in_ready_o = !k_v && !rst_i;
  assign acc = in_valid_i && in_ready_o;
  assign pop = m_v && out_ready_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_v <= 1'b0;
      k_v <= 1'b0;
      m_imm <= '0;
      m_fmt <= F_R;
      m_ill <= 1'b0;
      m_tag <= '0;
      cnt <= '0;
    end else begin
      if (acc && d_ill && cnt != '1) cnt <= cnt + 1'b1;
      if (flush_i) begin
        m_v <= 1'b0;
        k_v <= 1'b0;
      end else if (pop && k_v) begin
        m_v <= 1'b1;
        m_imm <= k_imm;
        m_fmt <= k_fmt;
        m_ill <= k_ill;
        m_tag <= k_tag;
        k_v <= 1'b0;
      end else if (acc && (!m_v || pop)) begin
        m_v <= 1'b1;
        m_imm <= d_imm;
        m_fmt <= d_fmt;
        m_ill <= d_ill;
        m_tag <= tag_i;
      end else if (acc) begin
        k_v <= 1'b1;
        k_imm <= d_imm;
        k_fmt <= d_fmt;
        k_ill <= d_ill;
        k_tag <= tag_i;
      end else if (pop) begin
        m_v <= 1'b0;
      end
    end
  end
  assign out_valid_o = m_v;
  assign imm_o = m_imm;
  assign fmt_o = m_fmt;
  assign illegal_o = m_ill;
  assign tag_o = m_tag;
  assign illegal_cnt_o = cnt;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives an XLEN=32/CNT_W=2 and an XLEN=64 instance in lockstep against a queue-based reference
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [7:0] tag;
  logic rdy32, v32, ill32, rdy64, v64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0] fmt32, fmt64;
  logic [7:0] tag32, tag64, cnt64;
  logic [1:0] cnt32;
  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(2)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy32),
    .instr_i(instr), .tag_i(tag), .out_valid_o(v32), .out_ready_i(out_ready), .imm_o(imm32),
    .fmt_o(fmt32), .illegal_o(ill32), .tag_o(tag32), .illegal_cnt_o(cnt32)
  );
  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(8)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy64),
    .instr_i(instr), .tag_i(tag), .out_valid_o(v64), .out_ready_i(out_ready), .imm_o(imm64),
    .fmt_o(fmt64), .illegal_o(ill64), .tag_o(tag64), .illegal_cnt_o(cnt64)
  );
  typedef struct {
    logic [31:0] ins;
    logic [7:0] tag;
  } ent_t;
  ent_t q[$];
  int exp_c32 = 0, exp_c64 = 0;
  bit fresh = 1'b0;
  int n_tests = 0, n_fail = 0;
  logic [6:0] ops[15] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17,
                          7'h6F, 7'h33, 7'h3B, 7'h1B, 7'h7F, 7'h00, 7'h0B};
  logic [31:0] dir[7] = '{32'hFFF00093, 32'hFE000EE3, 32'h123452B7, 32'h0010006F,
                          32'h4030D093, 32'hFE112C23, 32'h0050809B};
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic void ref_dec(input logic [31:0] ins, input bit rv64, output longint imm,
                                  output int fmt, output bit ill);
    bit shift;
    longint iv;
    shift = ins[14:12] == 3'b001 || ins[14:12] == 3'b101;
    iv = longint'(ins[31:20]) - (ins[31] ? 64'sd4096 : 64'sd0);
    imm = 0;
    fmt = 0;
    ill = 1'b0;
    case (ins[6:0])
      7'h13: begin
        fmt = 1;
        if (!shift) imm = iv;
        else if (rv64) imm = longint'(ins[25:20]);
        else imm = longint'(ins[24:20]);
      end
      7'h03, 7'h67, 7'h73: begin
        fmt = 1;
        imm = iv;
      end
      7'h23: begin
        fmt = 2;
        imm = longint'(ins[11:7]) + longint'(ins[30:25]) * 32 - (ins[31] ? 64'sd2048 : 64'sd0);
      end
      7'h63: begin
        fmt = 3;
        imm = longint'(ins[11:8]) * 2 + longint'(ins[30:25]) * 32 + (ins[7] ? 64'sd2048 : 64'sd0)
              - (ins[31] ? 64'sd4096 : 64'sd0);
      end
      7'h37, 7'h17: begin
        fmt = 4;
        imm = longint'(int'(ins & 32'hFFFFF000));
      end
      7'h6F: begin
        fmt = 5;
        imm = longint'(ins[30:21]) * 2 + (ins[20] ? 64'sd2048 : 64'sd0) + longint'(ins[19:12]) * 4096
              - (ins[31] ? 64'sd1048576 : 64'sd0);
      end
      7'h33: fmt = 0;
      7'h3B: ill = !rv64;
      7'h1B: begin
        if (rv64) begin
          fmt = 1;
          imm = shift ? longint'(ins[24:20]) : iv;
        end else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
  endfunction
  task automatic step(input bit r, input bit f, input bit v, input logic [31:0] i,
                      input logic [7:0] t, input bit ordy);
    bit acc, pop, ill;
    longint imm;
    int fmt;
    rst = r;
    flush = f;
    in_valid = v;
    instr = i;
    tag = t;
    out_ready = ordy;
    acc = v && !r && q.size() < 2;
    pop = !r && q.size() > 0 && ordy;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_c32 = 0;
      exp_c64 = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        ref_dec(i, 1'b0, imm, fmt, ill);
        if (ill && exp_c32 < 3) exp_c32++;
        ref_dec(i, 1'b1, imm, fmt, ill);
        if (ill && exp_c64 < 255) exp_c64++;
      end
      if (f) q.delete();
      else if (acc) q.push_back('{ins: i, tag: t});
    end
    fresh = r;
    @(negedge clk);
    check("valid32", 64'(v32), 64'(q.size() > 0));
    check("valid64", 64'(v64), 64'(q.size() > 0));
    check("ready32", 64'(rdy32), 64'(!rst && q.size() < 2));
    check("ready64", 64'(rdy64), 64'(!rst && q.size() < 2));
    check("cnt32", 64'(cnt32), 64'(exp_c32));
    check("cnt64", 64'(cnt64), 64'(exp_c64));
    if (q.size() > 0) begin
      ref_dec(q[0].ins, 1'b0, imm, fmt, ill);
      check("imm32", 64'(imm32), 64'(imm[31:0]));
      check("fmt32", 64'(fmt32), 64'(fmt[2:0]));
      check("ill32", 64'(ill32), 64'(ill));
      check("tag32", 64'(tag32), 64'(q[0].tag));
      ref_dec(q[0].ins, 1'b1, imm, fmt, ill);
      check("imm64", imm64, imm);
      check("fmt64", 64'(fmt64), 64'(fmt[2:0]));
      check("ill64", 64'(ill64), 64'(ill));
      check("tag64", 64'(tag64), 64'(q[0].tag));
    end
    if (fresh) begin
      check("rst_imm", {imm64[63:32], imm32} | {32'd0, imm64[31:0]}, 64'd0);
      check("rst_fmt", 64'({fmt32, fmt64}), 64'd0);
      check("rst_ill", 64'({ill32, ill64}), 64'd0);
      check("rst_tag", 64'({tag32, tag64}), 64'd0);
    end
  endtask
  initial begin
    logic [31:0] rnd;
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 32'h0000007F, 8'h55, 1);
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) step(0, 0, 1, dir[k], 8'(k + 10), 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h00000013, 8'd1, 0);
    step(0, 0, 1, 32'h00000013, 8'd2, 0);
    step(0, 0, 1, 32'h00000013, 8'd3, 0);
    step(0, 0, 1, 32'h00000013, 8'd3, 0);
    step(0, 0, 1, 32'h00000013, 8'd3, 1);
    step(0, 0, 1, 32'h00000013, 8'd3, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 32'h0000007F, 8'(k), 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h123452B7, 8'hA0, 0);
    step(0, 0, 1, 32'h0010006F, 8'hA1, 0);
    step(0, 1, 1, 32'hFE000EE3, 8'hA2, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h123452B7, 8'hB0, 0);
    step(0, 1, 1, 32'h0000007F, 8'hB1, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'hFFF00093, 8'hC0, 0);
    step(1, 1, 1, 32'hFFF00093, 8'hC1, 1);
    for (int k = 0; k < 3000; k++) begin
      rnd = $urandom();
      step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           {rnd[31:7], ops[$urandom_range(0, 14)]}, 8'($urandom()), $urandom_range(0, 2) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
